// File: rtl/unsaved_nios2_gen2_0_cpu_mult_combine_if.sv
// M-stage to W-stage multiply combine bus: operands and partial products in,
// stall and registered result out.
interface unsaved_nios2_gen2_0_cpu_mult_combine_if;
  logic        M_en;
  logic        M_valid_mul;
  logic [1:0]  M_op;
  logic [31:0] M_src1;
  logic [31:0] M_src2;
  logic [31:0] M_mul_cell_p1;
  logic [31:0] M_mul_cell_p2;
  logic [31:0] M_mul_cell_p3;
  logic        M_mul_stall;
  logic [31:0] W_mul_result;
  logic        W_mul_valid;

  modport master (
    output M_en, M_valid_mul, M_op, M_src1, M_src2,
    output M_mul_cell_p1, M_mul_cell_p2, M_mul_cell_p3,
    input  M_mul_stall, W_mul_result, W_mul_valid
  );

  modport slave (
    input  M_en, M_valid_mul, M_op, M_src1, M_src2,
    input  M_mul_cell_p1, M_mul_cell_p2, M_mul_cell_p3,
    output M_mul_stall, W_mul_result, W_mul_valid
  );
endinterface

// File: rtl/unsaved_nios2_gen2_0_cpu_mult_combine.sv
// Combines 16x16 partial products into the 32-bit mul result, or runs a short
// stalled sequence to form the upper half for mulxuu/mulxsu/mulxss.
module unsaved_nios2_gen2_0_cpu_mult_combine (
  input logic clk,
  input logic reset_n,
  unsaved_nios2_gen2_0_cpu_mult_combine_if.slave bus
);

  typedef enum logic [2:0] {IDLE, HI, SUM, CORR, DONE} state_t;

  state_t      state;
  logic [15:0] p1_hi_p0;
  logic [31:0] p2_p0;
  logic [31:0] p3_p0;
  logic [31:0] src1_p0;
  logic [31:0] src2_p0;
  logic [1:0]  op_p0;
  logic [31:0] p4_p1;
  logic [32:0] mid_p1;
  logic        c_p1;
  logic [31:0] uhi_p2;
  logic [31:0] mx_res;

  logic        start;
  logic [31:0] mid_in;
  logic [31:0] low;
  logic [32:0] mid_sum;
  logic [16:0] c_sum;

  // Subtract the cross terms that turn the unsigned high word into the
  // signed-by-unsigned or signed-by-signed high word.
  function automatic logic [31:0] sign_corr(input logic [1:0] op,
                                            input logic [31:0] hi,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
    logic [31:0] r;
    r = hi;
    if (op[1] && a[31])          r = r - b;
    if (op == 2'b11 && b[31])    r = r - a;
    return r;
  endfunction

  assign start   = (state == IDLE) && bus.M_valid_mul;
  assign mid_in  = bus.M_mul_cell_p2 + bus.M_mul_cell_p3;
  assign low     = bus.M_mul_cell_p1 + {mid_in[15:0], 16'b0};
  assign mid_sum = {1'b0, p2_p0} + {1'b0, p3_p0};
  assign c_sum   = {1'b0, p1_hi_p0} + {1'b0, mid_sum[15:0]};

  assign bus.M_mul_stall = (start && (bus.M_op != 2'b00)) ||
                           (state == HI) || (state == SUM) || (state == CORR);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= IDLE;
      p1_hi_p0         <= '0;
      p2_p0            <= '0;
      p3_p0            <= '0;
      src1_p0          <= '0;
      src2_p0          <= '0;
      op_p0            <= '0;
      p4_p1            <= '0;
      mid_p1           <= '0;
      c_p1             <= 1'b0;
      uhi_p2           <= '0;
      mx_res           <= '0;
      bus.W_mul_result <= '0;
      bus.W_mul_valid  <= 1'b0;
    end else begin
      bus.W_mul_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (bus.M_op == 2'b00) begin
              if (bus.M_en) begin
                bus.W_mul_result <= low;
                bus.W_mul_valid  <= 1'b1;
              end
            end else begin
              // mulx launches without waiting for M_en; the cell holds its outputs.
              p1_hi_p0 <= bus.M_mul_cell_p1[31:16];
              p2_p0    <= bus.M_mul_cell_p2;
              p3_p0    <= bus.M_mul_cell_p3;
              src1_p0  <= bus.M_src1;
              src2_p0  <= bus.M_src2;
              op_p0    <= bus.M_op;
              state    <= HI;
            end
          end
        end
        // HI: hi*hi product, middle sum and carry out of the low-word column
        HI: begin
          p4_p1  <= src1_p0[31:16] * src2_p0[31:16];
          mid_p1 <= mid_sum;
          c_p1   <= c_sum[16];
          state  <= SUM;
        end
        // SUM: unsigned upper word
        SUM: begin
          uhi_p2 <= p4_p1 + {15'b0, mid_p1[32:16]} + {31'b0, c_p1};
          state  <= CORR;
        end
        // CORR: signed corrections
        CORR: begin
          mx_res <= sign_corr(op_p0, uhi_p2, src1_p0, src2_p0);
          state  <= DONE;
        end
        DONE: begin
          if (bus.M_en) begin
            bus.W_mul_result <= mx_res;
            bus.W_mul_valid  <= 1'b1;
            state            <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_unsaved_nios2_gen2_0_cpu_mult_combine.sv
// Scoreboard bench: driver pushes expected results from a 64-bit product model,
// monitor pops and compares on every W_mul_valid.
module tb_unsaved_nios2_gen2_0_cpu_mult_combine;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  logic [31:0] exp_q[$];

  unsaved_nios2_gen2_0_cpu_mult_combine_if bus();

  unsaved_nios2_gen2_0_cpu_mult_combine dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Full 64-bit product with the signedness each opcode implies.
  function automatic logic [31:0] model(input logic [1:0] op,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    logic signed [63:0] sa, sb, prod;
    sa = (op[1])       ? {{32{a[31]}}, a} : {32'b0, a};
    sb = (op == 2'b11) ? {{32{b[31]}}, b} : {32'b0, b};
    prod = sa * sb;
    return (op == 2'b00) ? prod[31:0] : prod[63:32];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n && bus.W_mul_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_valid: got result %h with empty scoreboard", bus.W_mul_result);
      end else begin
        check("result", bus.W_mul_result, exp_q.pop_front());
      end
    end
  end

  task automatic drive_ops(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.M_op          = op;
    bus.M_src1        = a;
    bus.M_src2        = b;
    bus.M_mul_cell_p1 = a[15:0]  * b[15:0];
    bus.M_mul_cell_p2 = a[15:0]  * b[31:16];
    bus.M_mul_cell_p3 = a[31:16] * b[15:0];
  endtask

  // mode 0: M_en held 1; mode 1: random M_en; mode 2: M_en low for the first
  // two unstalled cycles of a mulx (DONE hold). Returns stall and cycle counts.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int mode, output int stalls, output int cycles);
    bit done;
    bit en, st;
    int hold;
    done = 0; hold = 0; stalls = 0; cycles = 0;
    drive_ops(op, a, b);
    bus.M_valid_mul = 1'b1;
    while (!done) begin
      #1;
      st = bus.M_mul_stall;
      if (mode == 2 && !st && hold < 2) begin
        en = 1'b0;
        hold++;
      end else if (mode == 1) begin
        en = ($urandom_range(0, 3) != 0);
      end else begin
        en = 1'b1;
      end
      bus.M_en = en;
      if (st) stalls++;
      @(posedge clk); #1;
      cycles++;
      if (mode == 2 && !en && !st) check("done_hold_no_valid", {31'b0, bus.W_mul_valid}, 32'd0);
      if (en && !st) done = 1;
      if (cycles > 60) begin
        n_vec++; n_err++;
        $display("FAIL timeout: op %0d not accepted in %0d cycles", op, cycles);
        done = 1;
      end
    end
    bus.M_valid_mul = 1'b0;
    bus.M_en = $urandom_range(0, 1);
  endtask

  task automatic directed(input string name, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] req, input int mode,
                          input int req_stalls);
    int s, c;
    exp_q.push_back(req);
    issue(op, a, b, mode, s, c);
    check({name, "_valid"}, {31'b0, bus.W_mul_valid}, 32'd1);
    check({name, "_stalls"}, s, req_stalls);
    if (mode == 0) check({name, "_cycles"}, c, (op == 2'b00) ? 32'd1 : 32'd5);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int s, c;
    logic [1:0] op;
    logic [31:0] a, b;
    bus.M_en = 1'b0;
    bus.M_valid_mul = 1'b0;
    drive_ops(2'b00, 32'h0, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    check("reset_result", bus.W_mul_result, 32'd0);
    check("reset_valid", {31'b0, bus.W_mul_valid}, 32'd0);
    check("reset_stall", {31'b0, bus.M_mul_stall}, 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    directed("mul_basic", 2'b00, 32'h0001_2345, 32'h0000_0100, 32'h0123_4500, 0, 0);
    directed("mulxuu_ff", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0, 4);
    directed("mulxss_m1", 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 0, 4);
    directed("mulxss_min", 2'b11, 32'h8000_0000, 32'h7FFF_FFFF, 32'hC000_0000, 0, 4);
    directed("mulxsu", 2'b10, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 0, 4);
    directed("carry", 2'b01, 32'h0001_FFFF, 32'h0001_FFFF, 32'h0000_0003, 0, 4);
    directed("done_hold", 2'b11, 32'h8765_4321, 32'hFEDC_BA98,
             model(2'b11, 32'h8765_4321, 32'hFEDC_BA98), 2, 4);
    // Back-to-back mulx right after DONE->IDLE
    directed("b2b_mulx", 2'b10, 32'h1234_5678, 32'h9ABC_DEF0,
             model(2'b10, 32'h1234_5678, 32'h9ABC_DEF0), 0, 4);

    // Mid-sequence reset: load a nonzero mul first, then abort a mulx in HI.
    directed("pre_reset", 2'b00, 32'h0000_1111, 32'h0000_0003, 32'h0000_3333, 0, 0);
    drive_ops(2'b01, 32'hDEAD_BEEF, 32'hCAFE_F00D);
    bus.M_valid_mul = 1'b1;
    bus.M_en = 1'b1;
    @(posedge clk); #1;
    check("in_hi_stall", {31'b0, bus.M_mul_stall}, 32'd1);
    bus.M_valid_mul = 1'b0;
    reset_n = 1'b0;
    #1;
    check("rst_mid_result", bus.W_mul_result, 32'd0);
    check("rst_mid_valid", {31'b0, bus.W_mul_valid}, 32'd0);
    check("rst_mid_stall", {31'b0, bus.M_mul_stall}, 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    directed("post_reset_mul", 2'b00, 32'hFFFF_FFFF, 32'h0000_0005, 32'hFFFF_FFFB, 0, 0);

    for (int i = 0; i < 80; i++) begin
      op = $urandom_range(0, 3);
      a = pick();
      b = pick();
      exp_q.push_back(model(op, a, b));
      issue(op, a, b, 1, s, c);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    bus.M_en = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
